// File: rtl/microwave_time_entry_pkg.sv
// Shared key codes, FSM encoding and digit widths for the microwave keypad controller.
package microwave_time_entry_pkg;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_STOP  = 4'hB;

  localparam int SU_W = 4;
  localparam int ST_W = 3;
  localparam int MU_W = 4;

  localparam int DEF_ALARM_CYCLES   = 3;
  localparam int DEF_QUICK_SEC_TENS = 3;
  localparam int DEF_GUARD_CYCLES   = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTRY  = 3'd1,
    S_LOAD   = 3'd2,
    S_COOK   = 3'd3,
    S_PAUSED = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/microwave_time_entry_digit_shifter.sv
// Three-digit M:SS entry register: shifts digits in from the right, counts them,
// and flags a digit that would overflow the count or make seconds-tens illegal.
module microwave_time_entry_digit_shifter
  import microwave_time_entry_pkg::*;
#(
  parameter int QUICK_SEC_TENS = DEF_QUICK_SEC_TENS
) (
  input  logic            CLK,
  input  logic            Clear,
  input  logic            i_clear,
  input  logic            i_preset,
  input  logic            i_restart,
  input  logic            i_shift,
  input  logic [SU_W-1:0] i_digit,
  output logic [SU_W-1:0] o_su,
  output logic [ST_W-1:0] o_st,
  output logic [MU_W-1:0] o_mu,
  output logic [1:0]      o_count,
  output logic            o_reject,
  output logic            o_zero
);

  logic [SU_W-1:0] r_su;
  logic [ST_W-1:0] r_st;
  logic [MU_W-1:0] r_mu;
  logic [1:0]      r_count;

  // Old units digit becomes seconds-tens on a shift, so it must be 0-5.
  assign o_reject = (r_count == 2'd3) || (r_su > 4'd5);
  assign o_zero   = (r_su == '0) && (r_st == '0) && (r_mu == '0);
  assign o_su     = r_su;
  assign o_st     = r_st;
  assign o_mu     = r_mu;
  assign o_count  = r_count;

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_su    <= '0;
      r_st    <= '0;
      r_mu    <= '0;
      r_count <= 2'd0;
    end else if (i_clear) begin
      r_su    <= '0;
      r_st    <= '0;
      r_mu    <= '0;
      r_count <= 2'd0;
    end else if (i_preset) begin
      r_su <= '0;
      r_st <= ST_W'(QUICK_SEC_TENS);
      r_mu <= '0;
    end else if (i_restart) begin
      r_su    <= i_digit;
      r_st    <= '0;
      r_mu    <= '0;
      r_count <= 2'd1;
    end else if (i_shift && !o_reject) begin
      r_mu    <= MU_W'(r_st);
      r_st    <= r_su[ST_W-1:0];
      r_su    <= i_digit;
      r_count <= r_count + 2'd1;
    end
  end

endmodule

// File: rtl/microwave_time_entry.sv
// Keypad-side controller for the M:SS countdown timer: digit entry, Load pulse,
// door/stop gating of Enable, and the end-of-cook alarm.
module microwave_time_entry
  import microwave_time_entry_pkg::*;
#(
  parameter int ALARM_CYCLES   = DEF_ALARM_CYCLES,
  parameter int QUICK_SEC_TENS = DEF_QUICK_SEC_TENS,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES
) (
  input  logic            CLK,
  input  logic            Clear,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            door_closed,
  input  logic            timer_done,
  output logic [SU_W-1:0] initial_seconds_units,
  output logic [ST_W-1:0] initial_seconds_tens,
  output logic [MU_W-1:0] initial_minutes_units,
  output logic            Load,
  output logic            Enable,
  output logic            alarm,
  output logic            entry_error,
  output logic [2:0]      state
);

  localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  state_t        r_state, w_next;
  logic [GW-1:0] r_guard;
  logic [AW-1:0] r_acnt;
  logic          r_load, r_enable, r_alarm, r_err;
  logic          w_err, w_clr, w_pre, w_restart, w_shift;
  logic          w_digit, w_start, w_stop, w_done;
  logic          w_reject, w_zero;
  logic [1:0]    w_count;

  assign w_digit = key_valid && is_digit(key_code);
  assign w_start = key_valid && (key_code == KEY_START);
  assign w_stop  = key_valid && (key_code == KEY_STOP);
  // timer_done still reflects the pre-Load count for a cycle or two after Load.
  assign w_done  = timer_done && (r_guard == '0);

  microwave_time_entry_digit_shifter #(
    .QUICK_SEC_TENS(QUICK_SEC_TENS)
  ) u_shifter (
    .CLK       (CLK),
    .Clear     (Clear),
    .i_clear   (w_clr),
    .i_preset  (w_pre),
    .i_restart (w_restart),
    .i_shift   (w_shift),
    .i_digit   (key_code),
    .o_su      (initial_seconds_units),
    .o_st      (initial_seconds_tens),
    .o_mu      (initial_minutes_units),
    .o_count   (w_count),
    .o_reject  (w_reject),
    .o_zero    (w_zero)
  );

  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_clr     = 1'b0;
    w_pre     = 1'b0;
    w_restart = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A first digit starts a fresh entry, discarding digits kept from the last cook.
        if (w_digit) begin
          w_restart = 1'b1;
          w_next    = S_ENTRY;
        end else if (w_start) begin
          if (!door_closed) begin
            w_err = 1'b1;
          end else begin
            w_pre  = (w_count == 2'd0);
            w_next = S_LOAD;
          end
        end else if (w_stop) begin
          w_clr = 1'b1;
        end
      end
      S_ENTRY: begin
        if (w_digit) begin
          if (w_reject) w_err = 1'b1;
          else          w_shift = 1'b1;
        end else if (w_start) begin
          if (!door_closed || w_zero) w_err = 1'b1;
          else                        w_next = S_LOAD;
        end else if (w_stop) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_LOAD: w_next = door_closed ? S_COOK : S_PAUSED;
      S_COOK: begin
        if (w_done)            w_next = S_DONE;
        else if (!door_closed) w_next = S_PAUSED;
        else if (w_stop)       w_next = S_PAUSED;
      end
      S_PAUSED: begin
        if (w_start) begin
          if (door_closed) w_next = S_COOK;
          else             w_err  = 1'b1;
        end else if (w_stop) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_DONE: begin
        if (key_valid || (r_acnt == '0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_state  <= S_IDLE;
      r_load   <= 1'b0;
      r_enable <= 1'b0;
      r_alarm  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_load   <= (w_next == S_LOAD);
      r_enable <= (w_next == S_COOK);
      r_alarm  <= (w_next == S_DONE);
      r_err    <= w_err;
    end
  end

  // Guard is armed only by a Load; resuming from PAUSED starts with it expired.
  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_guard <= '0;
    end else if (r_state == S_LOAD) begin
      r_guard <= GW'(GUARD_CYCLES);
    end else if (r_state == S_COOK) begin
      if (r_guard != '0) r_guard <= r_guard - GW'(1);
    end else begin
      r_guard <= '0;
    end
  end

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_acnt <= '0;
    end else if (r_state != S_DONE) begin
      r_acnt <= AW'(ALARM_CYCLES - 1);
    end else if (r_acnt != '0) begin
      r_acnt <= r_acnt - AW'(1);
    end
  end

  assign Load        = r_load;
  assign Enable      = r_enable;
  assign alarm       = r_alarm;
  assign entry_error = r_err;
  assign state       = r_state;

endmodule
